// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

    localparam int                 INSTR_W   = 32;
    localparam logic [31:0]        PC_STEP   = 32'd4;
    // An all-zero instruction word marks the end of the program.
    localparam logic [INSTR_W-1:0] HALT_WORD = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // One buffered fetch: the address and the word returned for it.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between fetch and decode; head is a register.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full blocks further pushes unless a pop happens in the same cycle.
//
// Ports: clk, rst_n (sync, active-low); push/push_dat write an entry, pop
// retires the head, flush empties the buffer (wins over push and pop);
// full/empty report occupancy; head is the oldest entry.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    fetch_entry_t ent0;   // head
    fetch_entry_t ent1;   // second-oldest
    logic [1:0]   count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_dat;
                    else               ent1 <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy is unchanged, the
                    // new word lands behind whatever survives the pop.
                    if (count == FULL_CNT) begin
                        ent0 <= ent1;
                        ent1 <= push_dat;
                    end else begin
                        ent0 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == 2'd0);
    assign head  = ent0;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, buffers returned words, halts on a zero word.
// Latency: a fetched word reaches if_instr one cycle after PC_out presents it.
// Backpressure: if_ready low fills the 2-entry buffer, then PC_out holds until a pop.
//
// Ports: clk, rst_n (sync, active-low); start leaves IDLE; redirect_valid /
// redirect_pc steer the PC and flush the buffer; PC_out / Instruction talk to
// the combinational instruction memory; if_valid / if_ready / if_instr / if_pc
// hand instructions to decode; halted is high while in HALT.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_DEPTH = 2    // only 2 is supported
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         PC_out,
    input  logic [INSTR_W-1:0]  Instruction,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [31:0]         if_pc,
    input  logic                if_ready,
    output logic                halted
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;

    logic         buf_full, buf_empty;
    logic         pop, fetch, push, flush;
    fetch_entry_t push_dat, head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    assign pop = !buf_empty && if_ready;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        // A redirect suppresses the fetch so the old path never leaks in.
        fetch     = (state == RUN) && !redirect_valid && (!buf_full || pop);
        push      = fetch && (Instruction != HALT_WORD);
        // The buffer is always empty in IDLE, so flushing there is harmless.
        flush     = redirect_valid;
        push_dat  = '{pc: pc, instr: Instruction};

        if (redirect_valid) begin
            state_nxt = RUN;
            pc_nxt    = {redirect_pc[31:2], 2'b00};
        end else begin
            case (state)
                IDLE: if (start) state_nxt = RUN;
                RUN: begin
                    if (push)       pc_nxt    = pc + PC_STEP;
                    else if (fetch) state_nxt = HALT;  // zero word: PC stays on it
                end
                HALT:    ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (flush),
        .full     (buf_full),
        .empty    (buf_empty),
        .head     (head)
    );

    assign PC_out   = pc;
    assign if_valid = !buf_empty;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] PC_out;
    logic [31:0] Instruction;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic        halted;

    logic [31:0] mem [64];
    logic [31:0] prog [8];
    localparam logic [31:0] WRAP_WORD = 32'h0BAD_F00D;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of {pc, instr} plus the PC and a mode
    // (0 = idle, 1 = run, 2 = halt), advanced once per clock edge.
    logic [63:0] m_q [$];
    logic [31:0] m_pc = 32'h0;
    int          m_mode = 0;

    always #5 clk = ~clk;

    assign Instruction = mem[PC_out[7:2]];

    fetch_controller #(
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .PC_out         (PC_out),
        .Instruction    (Instruction),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .halted         (halted)
    );

    task automatic model_update();
        logic [31:0] w;
        if (!rst_n) begin
            m_q.delete();
            m_pc   = 32'h0;
            m_mode = 0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc   = redirect_pc & 32'hFFFF_FFFC;
            m_mode = 1;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else begin
            if (if_ready && m_q.size() > 0) m_q.delete(0);
            if (m_mode == 1 && m_q.size() < 2) begin
                w = mem[m_pc[7:2]];
                if (w == 32'h0) m_mode = 2;
                else begin
                    m_q.push_back({m_pc, w});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; if_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_instr !== 32'h0) begin n_bad++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
        n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
        n_cmp++; if (PC_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc_out: got %h want 0", PC_out); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        rst_n = 1'b1; start = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (if_valid !== 1'b0 || PC_out !== 32'h0) begin
            n_bad++; $display("FAIL idle_no_fetch: got valid=%b pc_out=%h want 0/0", if_valid, PC_out);
        end
    endtask

    task automatic test_basic();
        int pops = 0;
        int cyc_28 = -1;
        int cyc_h = -1;
        do_reset();
        if_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL start_latency_early: got valid=%b want 0", if_valid); end
        tick();
        for (int c = 0; c < 40; c++) begin
            if (c == 0) begin
                n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL start_latency: got valid=%b want 1", if_valid); end
            end
            if (PC_out == 32'd28 && cyc_28 < 0) cyc_28 = c;
            if (halted && cyc_h < 0) cyc_h = c;
            if (if_valid && if_ready) begin
                n_cmp++;
                if (pops >= 7 || if_pc !== 32'(4 * pops) || if_instr !== prog[pops] || c != pops) begin
                    n_bad++; $display("FAIL basic_seq[%0d]: got pc=%h instr=%h cyc=%0d want pc=%h instr=%h cyc=%0d",
                                      pops, if_pc, if_instr, c, 32'(4 * pops), prog[pops % 8], pops);
                end
                pops++;
            end
            if (halted && !if_valid) break;
            tick();
        end
        n_cmp++; if (pops != 7) begin n_bad++; $display("FAIL basic_count: got %0d want 7", pops); end
        n_cmp++; if (halted !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL basic_halt: got halted=%b valid=%b want 1/0", halted, if_valid); end
        n_cmp++; if (PC_out !== 32'd28) begin n_bad++; $display("FAIL basic_halt_pc: got %h want 1c", PC_out); end
        n_cmp++; if (cyc_28 < 0 || cyc_h != cyc_28 + 1) begin n_bad++; $display("FAIL halt_timing: got halted cyc %0d want %0d", cyc_h, cyc_28 + 1); end
    endtask

    task automatic drain_to_halt(input string name);
        if_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (halted && !if_valid) break;
            tick();
        end
        n_cmp++; if (halted !== 1'b1 || if_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s_drain: got halted=%b valid=%b want 1/0", name, halted, if_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        if_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== prog[0]) begin
                n_bad++; $display("FAIL stall_head[%0d]: got valid=%b pc=%h instr=%h want 1/0/%h", i, if_valid, if_pc, if_instr, prog[0]);
            end
        end
        n_cmp++; if (PC_out !== 32'd8) begin n_bad++; $display("FAIL stall_pc_hold: got %h want 8", PC_out); end
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== prog[k]) begin
                n_bad++; $display("FAIL stall_release[%0d]: got valid=%b pc=%h instr=%h want 1/%h/%h", k, if_valid, if_pc, if_instr, 32'(4 * k), prog[k]);
            end
            tick();
        end
        drain_to_halt("stall");
    endtask

    task automatic test_redirect_flush();
        do_reset();
        if_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        tick();
        n_cmp++; if (if_pc !== 32'd4 || PC_out !== 32'd12) begin
            n_bad++; $display("FAIL flush_setup: got head=%h pc_out=%h want 4/c", if_pc, PC_out);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h13; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || PC_out !== 32'd16) begin
            n_bad++; $display("FAIL flush_discard: got valid=%b pc_out=%h want 0/10", if_valid, PC_out);
        end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd16 || if_instr !== 32'h014C1800) begin
            n_bad++; $display("FAIL flush_target: got valid=%b pc=%h instr=%h want 1/10/014c1800", if_valid, if_pc, if_instr);
        end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd20) begin
            n_bad++; $display("FAIL flush_follow: got valid=%b pc=%h want 1/14", if_valid, if_pc);
        end
        drain_to_halt("flush");
    endtask

    task automatic test_halt_redirect();
        int pops = 0;
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL hr_pre: got halted=%b want 1", halted); end
        redirect_valid = 1'b1; redirect_pc = 32'd12; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (halted !== 1'b0 || PC_out !== 32'd12) begin
            n_bad++; $display("FAIL hr_resume: got halted=%b pc_out=%h want 0/c", halted, PC_out);
        end
        for (int c = 0; c < 30; c++) begin
            if (if_valid && if_ready) begin
                n_cmp++; if (pops >= 4 || if_pc !== 32'(12 + 4 * pops) || if_instr !== prog[3 + pops]) begin
                    n_bad++; $display("FAIL hr_seq[%0d]: got pc=%h instr=%h want pc=%h", pops, if_pc, if_instr, 32'(12 + 4 * pops));
                end
                pops++;
            end
            if (halted && !if_valid) break;
            tick();
        end
        n_cmp++; if (pops != 4 || halted !== 1'b1) begin
            n_bad++; $display("FAIL hr_rehalt: got pops=%0d halted=%b want 4/1", pops, halted);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; if_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (PC_out !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_align: got %h want fffffffc", PC_out); end
        tick();
        n_cmp++; if (PC_out !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_instr !== WRAP_WORD) begin
            n_bad++; $display("FAIL wrap_step: got pc_out=%h head=%h instr=%h want 0/fffffffc/%h", PC_out, if_pc, if_instr, WRAP_WORD);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        if_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b1 || PC_out !== 32'd8) begin
            n_bad++; $display("FAIL midrun_setup: got valid=%b pc_out=%h want 1/8", if_valid, PC_out);
        end
        rst_n = 1'b0; start = 1'b1;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || PC_out !== 32'h0 || halted !== 1'b0) begin
            n_bad++; $display("FAIL midrun_reset: got valid=%b pc_out=%h halted=%b want 0/0/0", if_valid, PC_out, halted);
        end
        rst_n = 1'b1; start = 1'b0;
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b0 || PC_out !== 32'h0) begin
            n_bad++; $display("FAIL midrun_idle: got valid=%b pc_out=%h want 0/0", if_valid, PC_out);
        end
    endtask

    task automatic test_idle_redirect();
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd20;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (PC_out !== 32'd20 || if_valid !== 1'b0) begin
            n_bad++; $display("FAIL idle_redir_pc: got pc_out=%h valid=%b want 14/0", PC_out, if_valid);
        end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd20 || if_instr !== prog[5] || halted !== 1'b0) begin
            n_bad++; $display("FAIL idle_redir_head: got valid=%b pc=%h instr=%h halted=%b want 1/14/%h/0", if_valid, if_pc, if_instr, halted, prog[5]);
        end
    endtask

    task automatic test_random();
        logic [31:0] e_pc, e_in;
        for (int i = 8; i < 63; i++) mem[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            start          = ($urandom_range(0, 15) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            if_ready       = ($urandom_range(0, 3) != 0);
            n_cmp++;
            if (if_valid !== (m_q.size() != 0) || PC_out !== m_pc || halted !== (m_mode == 2)) begin
                n_bad++; $display("FAIL rand_ctl[%0d]: got valid=%b pc_out=%h halted=%b want %b/%h/%b",
                                  c, if_valid, PC_out, halted, m_q.size() != 0, m_pc, m_mode == 2);
            end
            if (m_q.size() != 0) begin
                e_pc = m_q[0][63:32];
                e_in = m_q[0][31:0];
                n_cmp++;
                if (if_pc !== e_pc || if_instr !== e_in) begin
                    n_bad++; $display("FAIL rand_head[%0d]: got pc=%h instr=%h want %h/%h", c, if_pc, if_instr, e_pc, e_in);
                end
            end
            tick();
        end
    endtask

    initial begin
        prog[0] = 32'h0022_0000; prog[1] = 32'h0064_0000; prog[2] = 32'h00A4_1000;
        prog[3] = 32'h00E8_1000; prog[4] = 32'h014C_1800; prog[5] = 32'h0124_0000;
        prog[6] = 32'h01AE_0000; prog[7] = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = (i < 8) ? prog[i] : ($urandom | 32'h1);
        mem[63] = WRAP_WORD;

        test_reset();
        test_basic();
        test_stall();
        test_redirect_flush();
        test_halt_redirect();
        test_wrap();
        test_reset_midrun();
        test_idle_redirect();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
